// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, word geometry and the byte-lane merge.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  be
    );
        logic [WORD_W-1:0] m;
        m = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the core's memory stage and the responder.
// The log_* group exposes each committed store for the simulation log.
interface dm_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        log_valid;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_data;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  log_valid, log_pc, log_addr, log_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output log_valid, log_pc, log_addr, log_data
    );

endinterface

// File: rtl/dm_word_ram.sv
// Word RAM: one synchronous byte-enabled write port, one asynchronous read.
// Contents are not reset; the responder's sweep clears them instead.
module dm_word_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANES-1:0]  be,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= be_merge(mem[waddr], wdata, be);
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: clears RAM after reset, then serves one load/store
// at a time with WAIT_CYCLES wait states and a one-cycle response pulse.
module dm_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST      = '1;
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep;
    logic [3:0]        cnt;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [3:0]        l_be;
    logic [31:0]       l_wdata;
    logic [31:0]       l_pc;

    logic              accept;
    logic              err;
    logic              commit;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    assign accept = (state == IDLE) & bus.req_valid;
    assign idx    = l_addr[ADDR_W+1:2];
    assign err    = (l_addr[1:0] != 2'b00) |
                    ((l_addr >> (ADDR_W + 2)) != 32'd0);
    assign commit = (state == RESP) & l_we & ~err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            sweep   <= '0;
            cnt     <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_be    <= '0;
            l_wdata <= '0;
            l_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) sweep <= sweep + 1'b1;
            if (accept) begin
                l_we    <= bus.req_we;
                l_addr  <= bus.req_addr;
                l_be    <= bus.req_be;
                l_wdata <= bus.req_wdata;
                l_pc    <= bus.req_pc;
                cnt     <= WAIT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (sweep == LAST) state_nxt = IDLE;
            IDLE: begin
                if (bus.req_valid)
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT:  if (cnt == 4'd1) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // The sweep owns the write port while clearing; stores use it in RESP.
    always_comb begin
        ram_we    = commit;
        ram_waddr = idx;
        ram_be    = l_be;
        ram_wdata = l_wdata;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep;
            ram_be    = 4'hF;
            ram_wdata = '0;
        end
    end

    dm_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .raddr (idx),
        .rdata (rd_word)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) & err;
    assign bus.resp_rdata = ((state == RESP) & ~l_we & ~err) ? rd_word : '0;

    assign bus.log_valid = commit;
    assign bus.log_pc    = l_pc;
    assign bus.log_addr  = l_addr;
    assign bus.log_data  = be_merge(rd_word, l_wdata, l_be);

endmodule
